// File: rtl/cnn_pkg.sv
// Shared types and helpers for the CNN layer stages (conv, pooling, resampling).
// State encoding is common across stages so the layer sequencer can observe any of them alike.
package cnn_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        INIT_WINDOW  = 3'd1,
        ISSUE_READ   = 3'd2,
        CAPTURE      = 3'd3,
        STORE_RESULT = 3'd4,
        WRITE_OUTPUT = 3'd5,
        DONE_ST      = 3'd6
    } state_t;

    function automatic int out_dim(input int in_dim, input int k, input int s, input int p);
        return (in_dim + 2 * p - k) / s + 1;
    endfunction

    // Linear NCHW offset of element (b, c, r, col) in a tensor of ch x h x w planes.
    function automatic logic [31:0] nchw_addr(input logic [31:0] b, input logic [31:0] c,
                                              input logic [31:0] r, input logic [31:0] col,
                                              input logic [31:0] ch, input logic [31:0] h,
                                              input logic [31:0] w);
        return ((b * ch + c) * h + r) * w + col;
    endfunction

endpackage

// File: rtl/maxpool_addr_gen.sv
// Purpose: NCHW read/write address generation from window and kernel counters.
// Latency: purely combinational, zero cycles.
// Backpressure: none; addresses follow the counters directly.
module maxpool_addr_gen
    import cnn_pkg::*;
#(
    parameter int CHANNELS   = 1,
    parameter int IN_HEIGHT  = 2,
    parameter int IN_WIDTH   = 2,
    parameter int POOL_SIZE  = 2,
    parameter int STRIDE     = 2,
    parameter int ADDR_WIDTH = 16
) (
    input  logic [CNT_W-1:0]      b_idx,
    input  logic [CNT_W-1:0]      c_idx,
    input  logic [CNT_W-1:0]      orow,
    input  logic [CNT_W-1:0]      ocol,
    input  logic [CNT_W-1:0]      krow,
    input  logic [CNT_W-1:0]      kcol,
    output logic [ADDR_WIDTH-1:0] in_addr,
    output logic [ADDR_WIDTH-1:0] out_addr
);

    localparam int OUT_H = out_dim(IN_HEIGHT, POOL_SIZE, STRIDE, 0);
    localparam int OUT_W = out_dim(IN_WIDTH, POOL_SIZE, STRIDE, 0);

    logic [31:0] irow;
    logic [31:0] icol;

    assign irow = 32'(orow) * 32'(STRIDE) + 32'(krow);
    assign icol = 32'(ocol) * 32'(STRIDE) + 32'(kcol);

    assign in_addr  = ADDR_WIDTH'(nchw_addr(32'(b_idx), 32'(c_idx), irow, icol,
                                            32'(CHANNELS), 32'(IN_HEIGHT), 32'(IN_WIDTH)));
    assign out_addr = ADDR_WIDTH'(nchw_addr(32'(b_idx), 32'(c_idx), 32'(orow), 32'(ocol),
                                            32'(CHANNELS), 32'(OUT_H), 32'(OUT_W)));

endmodule

// File: rtl/maxpool2d.sv
// Purpose: memory-mapped 2D max pooling over NCHW planes; MAXPOOL_RELU_EN clamps results at zero.
// Latency: done rises 1 + N_out*(3 + 2*POOL_SIZE^2) edges after start is sampled in IDLE.
// Backpressure: none; fixed-cadence single reads and one-cycle write pulses, start held stalls in DONE_ST.
module maxpool2d
    import cnn_pkg::*;
#(
    parameter int BATCH_SIZE = 1,
    parameter int CHANNELS   = 1,
    parameter int IN_HEIGHT  = 2,
    parameter int IN_WIDTH   = 2,
    parameter int POOL_SIZE  = 2,
    parameter int STRIDE     = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  done,
    output logic                  valid,
    output logic [ADDR_WIDTH-1:0] input_addr,
    input  logic [DATA_WIDTH-1:0] input_data,
    output logic                  input_en,
    output logic [ADDR_WIDTH-1:0] output_addr,
    output logic [DATA_WIDTH-1:0] output_data,
    output logic                  output_we,
    output logic                  output_en
);

    localparam int OUT_H = out_dim(IN_HEIGHT, POOL_SIZE, STRIDE, 0);
    localparam int OUT_W = out_dim(IN_WIDTH, POOL_SIZE, STRIDE, 0);

    state_t                 state;
    logic [CNT_W-1:0]       b_idx, c_idx, orow, ocol, krow, kcol;
    logic [CNT_W-1:0]       krow_nxt, kcol_nxt;
    logic                   first;
    logic signed [DATA_WIDTH-1:0] max_val;
    logic signed [DATA_WIDTH-1:0] store_val;
    logic [ADDR_WIDTH-1:0]  rd_addr, wr_addr;
    logic                   last_k, last_oc, last_or, last_c, last_b;

    // Reads are launched on entry to ISSUE_READ, so the generator sees the upcoming kernel position.
    maxpool_addr_gen #(
        .CHANNELS  (CHANNELS),
        .IN_HEIGHT (IN_HEIGHT),
        .IN_WIDTH  (IN_WIDTH),
        .POOL_SIZE (POOL_SIZE),
        .STRIDE    (STRIDE),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_addr_gen (
        .b_idx   (b_idx),
        .c_idx   (c_idx),
        .orow    (orow),
        .ocol    (ocol),
        .krow    (krow_nxt),
        .kcol    (kcol_nxt),
        .in_addr (rd_addr),
        .out_addr(wr_addr)
    );

    assign last_k  = (krow == CNT_W'(POOL_SIZE - 1)) && (kcol == CNT_W'(POOL_SIZE - 1));
    assign last_oc = (ocol == CNT_W'(OUT_W - 1));
    assign last_or = (orow == CNT_W'(OUT_H - 1));
    assign last_c  = (c_idx == CNT_W'(CHANNELS - 1));
    assign last_b  = (b_idx == CNT_W'(BATCH_SIZE - 1));

    always_comb begin
        krow_nxt = krow;
        kcol_nxt = kcol;
        if (state == INIT_WINDOW) begin
            krow_nxt = '0;
            kcol_nxt = '0;
        end else if (kcol == CNT_W'(POOL_SIZE - 1)) begin
            kcol_nxt = '0;
            krow_nxt = krow + 1'b1;
        end else begin
            kcol_nxt = kcol + 1'b1;
        end
    end

`ifdef MAXPOOL_RELU_EN
    assign store_val = max_val[DATA_WIDTH-1] ? '0 : max_val;
`else
    assign store_val = max_val;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            b_idx       <= '0;
            c_idx       <= '0;
            orow        <= '0;
            ocol        <= '0;
            krow        <= '0;
            kcol        <= '0;
            first       <= 1'b0;
            max_val     <= '0;
            done        <= 1'b0;
            valid       <= 1'b0;
            input_addr  <= '0;
            input_en    <= 1'b0;
            output_addr <= '0;
            output_data <= '0;
            output_we   <= 1'b0;
            output_en   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done  <= 1'b0;
                    valid <= 1'b0;
                    if (start) begin
                        b_idx <= '0;
                        c_idx <= '0;
                        orow  <= '0;
                        ocol  <= '0;
                        state <= INIT_WINDOW;
                    end
                end
                INIT_WINDOW: begin
                    krow       <= '0;
                    kcol       <= '0;
                    first      <= 1'b1;
                    input_addr <= rd_addr;
                    input_en   <= 1'b1;
                    state      <= ISSUE_READ;
                end
                ISSUE_READ: begin
                    input_en <= 1'b0;
                    state    <= CAPTURE;
                end
                CAPTURE: begin
                    // Strict compare: on ties the earliest element in scan order wins.
                    if (first || ($signed(input_data) > max_val))
                        max_val <= $signed(input_data);
                    first <= 1'b0;
                    if (!last_k) begin
                        krow       <= krow_nxt;
                        kcol       <= kcol_nxt;
                        input_addr <= rd_addr;
                        input_en   <= 1'b1;
                        state      <= ISSUE_READ;
                    end else begin
                        state <= STORE_RESULT;
                    end
                end
                STORE_RESULT: begin
                    output_addr <= wr_addr;
                    output_data <= store_val;
                    output_en   <= 1'b1;
                    output_we   <= 1'b1;
                    state       <= WRITE_OUTPUT;
                end
                WRITE_OUTPUT: begin
                    output_en <= 1'b0;
                    output_we <= 1'b0;
                    state     <= INIT_WINDOW;
                    if (!last_oc) begin
                        ocol <= ocol + 1'b1;
                    end else begin
                        ocol <= '0;
                        if (!last_or) begin
                            orow <= orow + 1'b1;
                        end else begin
                            orow <= '0;
                            if (!last_c) begin
                                c_idx <= c_idx + 1'b1;
                            end else begin
                                c_idx <= '0;
                                if (!last_b) begin
                                    b_idx <= b_idx + 1'b1;
                                end else begin
                                    b_idx <= '0;
                                    done  <= 1'b1;
                                    valid <= 1'b1;
                                    state <= DONE_ST;
                                end
                            end
                        end
                    end
                end
                DONE_ST: begin
                    if (!start) begin
                        done  <= 1'b0;
                        valid <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_maxpool2d.sv
// Bench for maxpool2d: three parameterisations share clk/rst, writes are checked against a scoreboard queue.
module tb_maxpool2d;

    localparam int CYC = 3 + 2 * 2 * 2;

    typedef struct {
        int dut;
        int addr;
        int data;
    } wr_t;

    typedef struct {
        int v0;
        int v1;
        int v2;
        int v3;
        int exp;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        start    [3];
    logic        done     [3];
    logic        valid    [3];
    logic        in_en    [3];
    logic        out_we   [3];
    logic        out_en   [3];
    logic [15:0] in_addr  [3];
    logic [15:0] out_addr [3];
    logic [31:0] in_data  [3];
    logic [31:0] out_data [3];
    logic signed [31:0] mem [3][16];

    wr_t exq[$];
    wr_t mon_e;
    int  checks;
    int  errors;

    maxpool2d u_a (
        .clk(clk), .rst(rst), .start(start[0]), .done(done[0]), .valid(valid[0]),
        .input_addr(in_addr[0]), .input_data(in_data[0]), .input_en(in_en[0]),
        .output_addr(out_addr[0]), .output_data(out_data[0]),
        .output_we(out_we[0]), .output_en(out_en[0])
    );

    maxpool2d #(.BATCH_SIZE(1), .CHANNELS(1), .IN_HEIGHT(4), .IN_WIDTH(4)) u_b (
        .clk(clk), .rst(rst), .start(start[1]), .done(done[1]), .valid(valid[1]),
        .input_addr(in_addr[1]), .input_data(in_data[1]), .input_en(in_en[1]),
        .output_addr(out_addr[1]), .output_data(out_data[1]),
        .output_we(out_we[1]), .output_en(out_en[1])
    );

    maxpool2d #(.BATCH_SIZE(2), .CHANNELS(2)) u_c (
        .clk(clk), .rst(rst), .start(start[2]), .done(done[2]), .valid(valid[2]),
        .input_addr(in_addr[2]), .input_data(in_data[2]), .input_en(in_en[2]),
        .output_addr(out_addr[2]), .output_data(out_data[2]),
        .output_we(out_we[2]), .output_en(out_en[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous read memories with one cycle of latency.
    always @(posedge clk) begin
        for (int g = 0; g < 3; g++)
            if (in_en[g]) in_data[g] <= mem[g][in_addr[g][3:0]];
    end

    task automatic check(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int relu(input int x);
`ifdef MAXPOOL_RELU_EN
        return (x < 0) ? 0 : x;
`else
        return x;
`endif
    endfunction

    task automatic push(input int g, input int addr, input int data);
        wr_t e;
        e.dut  = g;
        e.addr = addr;
        e.data = relu(data);
        exq.push_back(e);
    endtask

    // Reference model for 2x2/stride-2 pooling over a square H x H input held in mem[g].
    task automatic model_push(input int g, input int nb, input int nc, input int h);
        int oh, m, a, v;
        oh = (h - 2) / 2 + 1;
        for (int b = 0; b < nb; b++)
            for (int c = 0; c < nc; c++)
                for (int r = 0; r < oh; r++)
                    for (int q = 0; q < oh; q++) begin
                        for (int k = 0; k < 4; k++) begin
                            a = ((b * nc + c) * h + r * 2 + k / 2) * h + q * 2 + k % 2;
                            v = mem[g][a];
                            if (k == 0 || v > m) m = v;
                        end
                        push(g, ((b * nc + c) * oh + r) * oh + q, m);
                    end
    endtask

    task automatic check_idle(input int g);
        check("rst_done",   done[g],     0);
        check("rst_valid",  valid[g],    0);
        check("rst_in_en",  in_en[g],    0);
        check("rst_in_addr", in_addr[g], 0);
        check("rst_out_addr", out_addr[g], 0);
        check("rst_out_data", out_data[g], 0);
        check("rst_out_we", out_we[g],   0);
        check("rst_out_en", out_en[g],   0);
    endtask

    task automatic run_job(input int g, input int n_out, input int hold);
        int n;
        n = 0;
        @(negedge clk);
        start[g] = 1'b1;
        do begin
            @(posedge clk);
            n++;
            #1;
        end while (!done[g] && n < 3000);
        check("done_latency", n, 1 + n_out * CYC);
        check("valid_with_done", valid[g], 1);
        repeat (hold) begin
            @(negedge clk);
            check("hold_done", done[g], 1);
            check("hold_valid", valid[g], 1);
        end
        @(negedge clk);
        start[g] = 1'b0;
        @(posedge clk);
        #1;
        check("done_clear", done[g], 0);
        check("valid_clear", valid[g], 0);
        check("all_writes_seen", exq.size(), 0);
    endtask

    // Every write pulse is matched against the scoreboard; a pulse held two cycles pops twice.
    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (out_we[g]) begin
                if (exq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: dut%0d addr %0d data %0d, expected no write",
                             g, out_addr[g], $signed(out_data[g]));
                end else begin
                    mon_e = exq.pop_front();
                    check("wr_dut", g, mon_e.dut);
                    check("wr_addr", out_addr[g], mon_e.addr);
                    check("wr_data", $signed(out_data[g]), mon_e.data);
                end
                check("wr_en", out_en[g], 1);
            end
        end
    end

    initial begin
        vec_t vt[7];
        checks = 0;
        errors = 0;
        vt[0] = '{3, -1, 7, 2, 7};
        vt[1] = '{-5, -5, -5, -5, -5};
        vt[2] = '{4, 4, 4, 4, 4};
        vt[3] = '{-8, -3, -9, -4, -3};
        vt[4] = '{-2147483647 - 1, -1, -2147483647, -2, -1};
        vt[5] = '{0, 1, 2, 2147483647, 2147483647};
        vt[6] = '{10, -20, 9, 10, 10};

        rst = 1'b1;
        for (int g = 0; g < 3; g++) start[g] = 1'b0;
        #12;
        for (int g = 0; g < 3; g++) check_idle(g);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            mem[0][0] = vt[i].v0;
            mem[0][1] = vt[i].v1;
            mem[0][2] = vt[i].v2;
            mem[0][3] = vt[i].v3;
            push(0, 0, vt[i].exp);
            run_job(0, 1, 0);
        end

        // 4x4 ramp: windows give 5, 7, 13, 15.
        for (int k = 0; k < 16; k++) mem[1][k] = k;
        push(1, 0, 5);
        push(1, 1, 7);
        push(1, 2, 13);
        push(1, 3, 15);
        run_job(1, 4, 0);

        for (int k = 0; k < 16; k++) mem[1][k] = -5;
        model_push(1, 1, 1, 4);
        run_job(1, 4, 0);

        // B=2, C=2 planes in NCHW order, including an all-equal plane.
        mem[2][0]  = 1;   mem[2][1]  = 2;   mem[2][2]  = 3;   mem[2][3]  = 4;
        mem[2][4]  = -7;  mem[2][5]  = -3;  mem[2][6]  = -9;  mem[2][7]  = -8;
        mem[2][8]  = 4;   mem[2][9]  = 4;   mem[2][10] = 4;   mem[2][11] = 4;
        mem[2][12] = 0;   mem[2][13] = -2147483647 - 1; mem[2][14] = 5; mem[2][15] = -1;
        push(2, 0, 4);
        push(2, 1, -3);
        push(2, 2, 4);
        push(2, 3, 5);
        run_job(2, 4, 0);

        // Reset during the second window's first CAPTURE: only the first write may appear.
        for (int k = 0; k < 16; k++) mem[1][k] = 15 - k;
        push(1, 0, 15);
        @(negedge clk);
        start[1] = 1'b1;
        repeat (2 + CYC + 1) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_idle(1);
        start[1] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("rst_abort_pending", exq.size(), 0);
        model_push(1, 1, 1, 4);
        run_job(1, 4, 0);

        // Start held high through completion keeps done/valid asserted.
        mem[0][0] = -1; mem[0][1] = 6; mem[0][2] = 6; mem[0][3] = -9;
        push(0, 0, 6);
        run_job(0, 1, 5);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
